// File: rtl/arp_rx_sched.sv
// ARP receive scheduler: buffers qualifying ARP request/reply events in a
// circular queue, exposes the head entry through a small read map, counts
// events lost to a full queue and raises a level interrupt either when
// enough entries are waiting or when the oldest has waited too long.
module arp_rx_sched #(
    parameter int DEPTH       = 4,
    parameter int IRQ_THRESH  = 2,
    parameter int IRQ_TIMEOUT = 1024
) (
    input  logic        rst_n,
    input  logic        i_rx_clk,
    input  logic [1:0]  i_pkt_type,
    input  logic [47:0] i_SHA,
    input  logic [31:0] i_SPA,
    input  logic [31:0] i_TPA,
    input  logic [31:0] i_local_ip,
    input  logic        i_filter_en,
    input  logic [2:0]  i_rd_addr,
    input  logic        i_rd,
    input  logic        i_pop,
    output logic [31:0] o_rd_data,
    output logic [4:0]  o_count,
    output logic        o_irq,
    output logic [7:0]  o_ovf_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(IRQ_TIMEOUT + 1);
    localparam logic [4:0]    DEPTH_C  = 5'(DEPTH);
    localparam logic [4:0]    THRESH_C = 5'(IRQ_THRESH);
    localparam logic [TW-1:0] TO_LAST  = TW'(IRQ_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ASSERT = 2'd2
    } irq_state_t;

    // Entry layout: {type[1:0], SHA[47:0], SPA[31:0]}
    logic [81:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [4:0]    count_reg;
    logic [7:0]    ovf_reg;
    logic [31:0]   rd_data_reg, rd_word;
    irq_state_t    state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          irq_reg;

    logic          push_req, push_ok, pop_ok, full, empty;
    logic [81:0]   head;

    assign empty = (count_reg == 5'd0);
    assign full  = (count_reg == DEPTH_C);
    assign head  = mem[rd_ptr_reg];

    // Requests may be filtered on TPA; replies are always accepted
    assign push_req = (i_pkt_type == 2'b10) ||
                      ((i_pkt_type == 2'b01) && (!i_filter_en || (i_TPA == i_local_ip)));
    assign pop_ok   = i_pop && !empty;
    // A same-cycle pop frees the slot, so a push into a full queue still lands
    assign push_ok  = push_req && (!full || pop_ok);

    // Entry storage: written in the event's arrival cycle, no reset needed
    always_ff @(posedge i_rx_clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= {i_pkt_type, i_SHA, i_SPA};
        end
    end

    // Queue pointers, occupancy and saturating overflow counter
    always_ff @(posedge i_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= 5'd0;
            ovf_reg    <= 8'd0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 5'd1;
                2'b01:   count_reg <= count_reg - 5'd1;
                default: count_reg <= count_reg;
            endcase
            if (push_req && full && !pop_ok && (ovf_reg != 8'hFF)) begin
                ovf_reg <= ovf_reg + 8'd1;
            end
        end
    end

    // Read map over the head entry; empty queue reads back as zero fields
    always_comb begin
        rd_word = 32'h0;
        case (i_rd_addr)
            3'd0: rd_word = {(empty ? 2'b00 : head[81:80]), 22'h0, 3'b000, count_reg};
            3'd1: rd_word = empty ? 32'h0 : head[31:0];
            3'd2: rd_word = empty ? 32'h0 : head[79:48];
            3'd3: rd_word = empty ? 32'h0 : {16'h0, head[47:32]};
            3'd4: rd_word = {24'h0, ovf_reg};
            default: rd_word = 32'h0;
        endcase
    end

    // Read data captures the pre-pop head and holds between strobes
    always_ff @(posedge i_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= 32'h0;
        end else if (i_rd) begin
            rd_data_reg <= rd_word;
        end
    end

    // IRQ FSM state, wait timer and registered interrupt output
    always_ff @(posedge i_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            timer_reg <= '0;
            irq_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            irq_reg   <= (state_next == ST_ASSERT);
        end
    end

    // IRQ next-state: threshold or timeout asserts, draining the queue releases
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        case (state_reg)
            ST_IDLE: begin
                timer_next = '0;
                if (!empty) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (empty) begin
                    state_next = ST_IDLE;
                    timer_next = '0;
                end else if ((count_reg >= THRESH_C) || (timer_reg == TO_LAST)) begin
                    state_next = ST_ASSERT;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            ST_ASSERT: begin
                if (empty) begin
                    state_next = ST_IDLE;
                    timer_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                timer_next = '0;
            end
        endcase
    end

    assign o_rd_data = rd_data_reg;
    assign o_count   = count_reg;
    assign o_irq     = irq_reg;
    assign o_ovf_cnt = ovf_reg;

endmodule

// File: tb/tb_arp_rx_sched.sv
// Directed bench for arp_rx_sched: stimulus queues expected read results,
// a monitor checks each read response (plus count/irq/ovf) as it appears.
module tb_arp_rx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pkt_type;
    logic [47:0] sha;
    logic [31:0] spa, tpa, local_ip;
    logic        filter_en;
    logic [2:0]  rd_addr;
    logic        rd, pop;
    logic [31:0] rd_data;
    logic [4:0]  count;
    logic        irq;
    logic [7:0]  ovf_cnt;

    always #5 clk = ~clk;

    arp_rx_sched #(.DEPTH(4), .IRQ_THRESH(2), .IRQ_TIMEOUT(1024)) dut (
        .rst_n      (rst_n),
        .i_rx_clk   (clk),
        .i_pkt_type (pkt_type),
        .i_SHA      (sha),
        .i_SPA      (spa),
        .i_TPA      (tpa),
        .i_local_ip (local_ip),
        .i_filter_en(filter_en),
        .i_rd_addr  (rd_addr),
        .i_rd       (rd),
        .i_pop      (pop),
        .o_rd_data  (rd_data),
        .o_count    (count),
        .o_irq      (irq),
        .o_ovf_cnt  (ovf_cnt)
    );

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        logic [4:0]  cnt;
        logic        irq;
        logic [7:0]  ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a read strobe seen at an edge has its response checked on the next negedge
    logic rd_d;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_d <= 1'b0;
        else        rd_d <= rd;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rd_d) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_underflow: got read response %h expected none queued", rd_data);
            end else begin
                e = sb.pop_front();
                $display("txn read addr=%0d data=%h count=%0d irq=%0b ovf=%0d",
                         e.addr, rd_data, count, irq, ovf_cnt);
                chk("rd_data", rd_data, e.data);
                chk("count", 32'(count), 32'(e.cnt));
                chk("irq", 32'(irq), 32'(e.irq));
                chk("ovf", 32'(ovf_cnt), 32'(e.ovf));
            end
        end
    end

    task automatic ev(input logic [1:0] t, input logic [47:0] s_ha, input logic [31:0] s_pa,
                      input logic [31:0] t_pa, input logic p, input logic r, input logic [2:0] a);
        pkt_type = t; sha = s_ha; spa = s_pa; tpa = t_pa;
        pop = p; rd = r; rd_addr = a;
        @(negedge clk);
        pkt_type = 2'b00; pop = 1'b0; rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) ev(2'b00, 48'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
    endtask

    // Issue a read (optionally with pop); expected values are for just after the edge
    task automatic rdx(input logic [2:0] a, input logic [31:0] d, input logic [4:0] c,
                       input logic i, input logic [7:0] o, input logic p);
        exp_t e;
        e.addr = a; e.data = d; e.cnt = c; e.irq = i; e.ovf = o;
        sb.push_back(e);
        ev(2'b00, 48'h0, 32'h0, 32'h0, p, 1'b1, a);
    endtask

    initial begin
        int k;
        int rise;
        rst_n = 1'b0; pkt_type = 2'b00; sha = '0; spa = '0; tpa = '0;
        local_ip = 32'h0; filter_en = 1'b0; rd_addr = 3'd0; rd = 1'b0; pop = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_ovf", 32'(ovf_cnt), 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        idle(1);
        chk("post_reset_count", 32'(count), 32'd0);

        // Single request, filter off, then wait for the timeout interrupt
        ev(2'b01, 48'h001122334455, 32'hC0A80105, 32'h0, 1'b0, 1'b0, 3'd0);
        rdx(3'd1, 32'hC0A80105, 5'd1, 1'b0, 8'd0, 1'b0);
        rdx(3'd2, 32'h00112233, 5'd1, 1'b0, 8'd0, 1'b0);
        rdx(3'd3, 32'h00004455, 5'd1, 1'b0, 8'd0, 1'b0);
        rdx(3'd0, 32'h40000001, 5'd1, 1'b0, 8'd0, 1'b0);
        k = 4; rise = -1;
        while (k < 1200 && rise < 0) begin
            idle(1);
            k++;
            if (irq) rise = k;
        end
        n_cmp++;
        if (rise < 1024 || rise > 1026) begin
            n_err++;
            $display("FAIL irq_timeout: got rise after %0d edges expected 1024..1026", rise);
        end
        rdx(3'd0, 32'h40000001, 5'd0, 1'b1, 8'd0, 1'b1);
        rdx(3'd0, 32'h00000000, 5'd0, 1'b0, 8'd0, 1'b0);

        // Two replies three cycles apart: threshold interrupt, then drain
        ev(2'b10, 48'hAABBCCDDEEFF, 32'h0A000001, 32'h0, 1'b0, 1'b0, 3'd0);
        idle(2);
        ev(2'b10, 48'h102030405060, 32'h0A000002, 32'h0, 1'b0, 1'b0, 3'd0);
        chk("thresh_count", 32'(count), 32'd2);
        chk("thresh_irq_before", 32'(irq), 32'd0);
        idle(1);
        chk("thresh_irq_after", 32'(irq), 32'd1);
        rdx(3'd1, 32'h0A000001, 5'd1, 1'b1, 8'd0, 1'b1);
        rdx(3'd2, 32'h10203040, 5'd0, 1'b1, 8'd0, 1'b1);
        rdx(3'd3, 32'h00000000, 5'd0, 1'b0, 8'd0, 1'b0);

        // TPA filtering
        filter_en = 1'b1; local_ip = 32'hC0A80101;
        ev(2'b01, 48'h0A0B0C0D0E0F, 32'hDEAD0001, 32'hC0A80102, 1'b0, 1'b0, 3'd0);
        rdx(3'd0, 32'h00000000, 5'd0, 1'b0, 8'd0, 1'b0);
        rdx(3'd4, 32'h00000000, 5'd0, 1'b0, 8'd0, 1'b0);
        ev(2'b01, 48'h0A0B0C0D0E0F, 32'h01020304, 32'hC0A80101, 1'b0, 1'b0, 3'd0);
        rdx(3'd0, 32'h40000001, 5'd1, 1'b0, 8'd0, 1'b0);
        ev(2'b10, 48'h111111111111, 32'h05060708, 32'h12345678, 1'b0, 1'b0, 3'd0);
        rdx(3'd0, 32'h40000002, 5'd2, 1'b1, 8'd0, 1'b0);
        rdx(3'd1, 32'h01020304, 5'd1, 1'b1, 8'd0, 1'b1);
        rdx(3'd1, 32'h05060708, 5'd0, 1'b1, 8'd0, 1'b1);
        rdx(3'd0, 32'h00000000, 5'd0, 1'b0, 8'd0, 1'b0);
        filter_en = 1'b0;

        // Overfill, then push+pop while full
        for (int i = 0; i < 6; i++) begin
            ev(2'b10, 48'h000000000100 + 48'(i), 32'h00000100 + 32'(i), 32'h0, 1'b0, 1'b0, 3'd0);
        end
        rdx(3'd0, 32'h80000004, 5'd4, 1'b1, 8'd2, 1'b0);
        rdx(3'd1, 32'h00000100, 5'd4, 1'b1, 8'd2, 1'b0);
        ev(2'b01, 48'hABCDEF012345, 32'h00000200, 32'h0, 1'b1, 1'b0, 3'd0);
        rdx(3'd4, 32'h00000002, 5'd4, 1'b1, 8'd2, 1'b0);
        rdx(3'd1, 32'h00000101, 5'd3, 1'b1, 8'd2, 1'b1);
        rdx(3'd1, 32'h00000102, 5'd2, 1'b1, 8'd2, 1'b1);
        rdx(3'd1, 32'h00000103, 5'd1, 1'b1, 8'd2, 1'b1);
        rdx(3'd0, 32'h40000001, 5'd1, 1'b1, 8'd2, 1'b0);
        rdx(3'd2, 32'hABCDEF01, 5'd0, 1'b1, 8'd2, 1'b1);
        rdx(3'd3, 32'h00000000, 5'd0, 1'b0, 8'd2, 1'b0);

        // Pop on empty, invalid type, then overflow saturation
        ev(2'b00, 48'h0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd0);
        ev(2'b11, 48'h123456789ABC, 32'h00000999, 32'h0, 1'b0, 1'b0, 3'd0);
        idle(3);
        rdx(3'd0, 32'h00000000, 5'd0, 1'b0, 8'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ev(2'b10, 48'h0000000003AA, 32'h00000300 + 32'(i), 32'h0, 1'b0, 1'b0, 3'd0);
        end
        for (int i = 0; i < 252; i++) begin
            ev(2'b10, 48'h0000000004BB, 32'h00000400, 32'h0, 1'b0, 1'b0, 3'd0);
        end
        rdx(3'd4, 32'h000000FE, 5'd4, 1'b1, 8'd254, 1'b0);
        for (int i = 0; i < 48; i++) begin
            ev(2'b10, 48'h0000000004BB, 32'h00000400, 32'h0, 1'b0, 1'b0, 3'd0);
        end
        rdx(3'd4, 32'h000000FF, 5'd4, 1'b1, 8'd255, 1'b0);

        // Asynchronous reset with three entries queued and irq high
        rdx(3'd0, 32'h80000004, 5'd3, 1'b1, 8'd255, 1'b1);
        chk("pre_reset_count", 32'(count), 32'd3);
        chk("pre_reset_irq", 32'(irq), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_irq", 32'(irq), 32'd0);
        chk("async_rst_ovf", 32'(ovf_cnt), 32'd0);
        chk("async_rst_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("post_rel_count", 32'(count), 32'd0);
        rdx(3'd0, 32'h00000000, 5'd0, 1'b0, 8'd0, 1'b0);
        rdx(3'd1, 32'h00000000, 5'd0, 1'b0, 8'd0, 1'b0);

        idle(2);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
